iolatch_nxd: RTL and testbench
==============================

Name: iolatch_nxd

Overview:
Parametrised bus-cycle latch and non-existent-device (NXD) watchdog for the KS-10 CPU.
- One independent channel per bus target (default: channel 0 = memory, channel 1 = IO).
- Each channel holds a busy latch from microcode cycle start until the device acknowledges.
- A channel that waits longer than TIMEOUT enabled clocks is aborted and flagged as non-existent.
- Outputs feed the microsequencer wait logic and the page-fail/interrupt logic.

Parameters:
CHANNELS, 2, number of independent bus channels (1..8).
TIMEOUT, 64, enabled clocks a cycle may stay busy before NXD is declared (2..2**CNT_WIDTH-1).
CNT_WIDTH, 8, width of each channel's timeout counter.

Ports:
clk  input  1  system clock.
rst  input  1  reset; synchronous, active-low.
clken  input  1  clock enable; all state advances only when high.
start  input  CHANNELS  one-hot-per-channel cycle-start request from microcode decode.
ack  input  CHANNELS  per-channel device acknowledge.
clr_nxd  input  1  clears all sticky NXD flags.
busy  output  CHANNELS  per-channel busy latch.
nxd  output  CHANNELS  per-channel sticky NXD flag.
nxd_pulse  output  1  high for one enabled cycle when any channel times out.
wait_req  output  1  OR of busy; stalls the microsequencer.

Behaviour:
Reset:
- On any clk edge with rst=0, regardless of clken: busy=0, nxd=0, nxd_pulse=0, counters=0.
- wait_req is combinational from busy, so it is 0 during reset.
- Reset mid-cycle abandons the cycle; a late ack after reset is ignored.

Clock enable:
- When clken=0, all registers hold, including counters and nxd_pulse.
- Inputs are sampled only on edges with clken=1.

Per-channel FSM (states IDLE, BUSY):
- IDLE, start[i]=1: enter BUSY; busy[i]=1 from the next cycle; counter cleared to 0.
- IDLE, ack[i]=1: ignored (stray ack), including when it coincides with start[i]; start wins.
- BUSY, ack[i]=1: return to IDLE; busy[i]=0 from the next cycle.
- BUSY, no ack: counter increments each enabled edge.
- BUSY, counter==TIMEOUT-1 and no ack: return to IDLE, set nxd[i], assert nxd_pulse.
  - busy[i] therefore stays high for exactly TIMEOUT enabled cycles.
- BUSY, ack[i] and timeout on the same edge: ack wins; no NXD.
- BUSY, start[i]: ignored; the counter is not restarted.
- Channels are fully independent; simultaneous events on different channels are all honoured.

Counter width:
- Counters never wrap.
- TIMEOUT > 2**CNT_WIDTH-1 is an elaboration error (generate-time check).

NXD flags:
- nxd[i] is sticky until clr_nxd=1 on an enabled edge, which clears all channels.
- If a set and a clr_nxd hit the same channel on the same edge, the set wins (no lost error).

nxd_pulse:
- Registered; high for exactly one enabled cycle after the edge on which any channel timed out.
- Multiple simultaneous timeouts produce a single pulse.
- Back-to-back timeouts on successive edges hold it high.

Latency: start/ack to busy is 1 cycle; timeout to nxd/nxd_pulse is 1 cycle; no combinational input-to-output paths except busy to wait_req.

Decomposition:
Shared package (ks10 cpu package):
- Channel index constants NXD_CH_MEM=0, NXD_CH_IO=1.
- Default NXD_TIMEOUT=64.
- Channel state encoding IDLE=1'b0, BUSY=1'b1.

Sub-module iolatch_nxd_chan:
- One channel: FSM, counter, sticky flag, and a timeout strobe.
- Instantiated CHANNELS times via generate.
- Top level ORs the strobes into nxd_pulse and the busy bits into wait_req.

Test Plan:
- Reset: rst=0 for 2 clocks while start=2'b11 -> busy=0, nxd=0, nxd_pulse=0, wait_req=0.
- Normal IO cycle: start=2'b10, ack[1] 5 cycles later -> busy[1]=1 for exactly 5 cycles, wait_req tracks it, nxd stays 0.
- Timeout: TIMEOUT=8, start[0], no ack -> busy[0] high 8 cycles, then nxd[0]=1 and nxd_pulse high one cycle; clr_nxd clears nxd[0].
- Tie cases:
  - ack[0] on the timeout edge -> no NXD.
  - clr_nxd on the timeout edge -> nxd[0]=1.
  - start+ack in IDLE -> BUSY.
- clken stall: start, then clken=0 for 20 cycles mid-count, TIMEOUT=8 -> busy persists, timeout occurs after 8 enabled cycles total.
- Reset mid-cycle and independence:
  - rst during BUSY -> IDLE, and a late ack is ignored.
  - Both channels time out on the same edge -> nxd=2'b11 with a single nxd_pulse.

Source files
------------

// File: rtl/iolatch_nxd_pkg.sv
// ---------------------------------------------------------------------------
// iolatch_nxd_pkg
// Shared constants and types for the KS-10 bus-cycle latch / NXD watchdog.
//   NXD_CH_MEM / NXD_CH_IO : channel index of the memory and IO bus targets
//   NXD_TIMEOUT            : default enabled-clock budget before NXD is declared
//   chan_state_t           : per-channel latch state (IDLE / BUSY)
// ---------------------------------------------------------------------------
package iolatch_nxd_pkg;

    localparam int NXD_CH_MEM  = 0;
    localparam int NXD_CH_IO   = 1;
    localparam int NXD_TIMEOUT = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chan_state_t;

endpackage

// File: rtl/iolatch_nxd_chan.sv
// ---------------------------------------------------------------------------
// iolatch_nxd_chan
// One bus channel: busy latch, timeout counter, sticky NXD flag.
// Ports:
//   clk, rst (sync, active-low), clken  - clocking
//   start_i    - cycle start request for this channel
//   ack_i      - device acknowledge for this channel
//   clr_nxd_i  - clear the sticky NXD flag
//   busy_o     - channel is waiting for an acknowledge
//   nxd_o      - sticky non-existent-device flag
//   tmo_o      - combinational strobe: this enabled edge is a timeout edge
// ---------------------------------------------------------------------------
module iolatch_nxd_chan
    import iolatch_nxd_pkg::*;
#(
    parameter int TIMEOUT   = NXD_TIMEOUT,
    parameter int CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clken,
    input  logic start_i,
    input  logic ack_i,
    input  logic clr_nxd_i,
    output logic busy_o,
    output logic nxd_o,
    output logic tmo_o
);

    // Counter value on the last busy edge; reaching it without an ack aborts.
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT - 1);

    chan_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 nxd_q, nxd_d;
    logic                 tmo;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                // A stray ack in IDLE is ignored; start wins when both arrive.
                if (start_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // Ack has priority over a timeout on the same edge; start is ignored.
                if (ack_i) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    tmo     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new error must not be lost to a simultaneous clear.
        if (tmo) begin
            nxd_d = 1'b1;
        end else if (clr_nxd_i) begin
            nxd_d = 1'b0;
        end else begin
            nxd_d = nxd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nxd_q   <= 1'b0;
        end else if (clken) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nxd_q   <= nxd_d;
        end
    end

    assign busy_o = (state_q == BUSY);
    assign nxd_o  = nxd_q;
    assign tmo_o  = tmo & clken;

endmodule

// File: rtl/iolatch_nxd.sv
// ---------------------------------------------------------------------------
// iolatch_nxd
// Parametrised bus-cycle latch and non-existent-device watchdog.
// Ports:
//   clk, rst (sync, active-low), clken  - clocking
//   start[CHANNELS]   - per-channel cycle start from microcode decode
//   ack[CHANNELS]     - per-channel device acknowledge
//   clr_nxd           - clears all sticky NXD flags
//   busy[CHANNELS]    - per-channel busy latch
//   nxd[CHANNELS]     - per-channel sticky NXD flag
//   nxd_pulse         - one enabled cycle after any channel times out
//   wait_req          - OR of busy, stalls the microsequencer
// ---------------------------------------------------------------------------
module iolatch_nxd
    import iolatch_nxd_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int TIMEOUT   = NXD_TIMEOUT,
    parameter int CNT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] ack,
    input  logic                clr_nxd,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] nxd,
    output logic                nxd_pulse,
    output logic                wait_req
);

    if ((TIMEOUT < 2) || (TIMEOUT > (2 ** CNT_WIDTH) - 1)) begin : g_bad_timeout
        $error("iolatch_nxd: TIMEOUT %0d out of range for CNT_WIDTH %0d", TIMEOUT, CNT_WIDTH);
    end
    if ((CHANNELS < 1) || (CHANNELS > 8)) begin : g_bad_channels
        $error("iolatch_nxd: CHANNELS %0d out of range 1..8", CHANNELS);
    end

    logic [CHANNELS-1:0] tmo;
    logic                nxd_pulse_q, nxd_pulse_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        iolatch_nxd_chan #(
            .TIMEOUT   (TIMEOUT),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .clken     (clken),
            .start_i   (start[i]),
            .ack_i     (ack[i]),
            .clr_nxd_i (clr_nxd),
            .busy_o    (busy[i]),
            .nxd_o     (nxd[i]),
            .tmo_o     (tmo[i])
        );
    end

    // Simultaneous timeouts collapse into one pulse.
    assign nxd_pulse_d = |tmo;

    always_ff @(posedge clk) begin
        if (!rst) begin
            nxd_pulse_q <= 1'b0;
        end else if (clken) begin
            nxd_pulse_q <= nxd_pulse_d;
        end
    end

    assign nxd_pulse = nxd_pulse_q;
    assign wait_req  = |busy;

endmodule

// File: tb/tb_iolatch_nxd.sv
module tb_iolatch_nxd;

    localparam int CH  = 2;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clken = 1'b0;
    logic [CH-1:0] start = '0;
    logic [CH-1:0] ack = '0;
    logic          clr_nxd = 1'b0;
    logic [CH-1:0] busy;
    logic [CH-1:0] nxd;
    logic          nxd_pulse;
    logic          wait_req;

    iolatch_nxd #(
        .CHANNELS  (CH),
        .TIMEOUT   (TMO),
        .CNT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .start     (start),
        .ack       (ack),
        .clr_nxd   (clr_nxd),
        .busy      (busy),
        .nxd       (nxd),
        .nxd_pulse (nxd_pulse),
        .wait_req  (wait_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] busy;
        logic [CH-1:0] nxd;
        logic          pulse;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a cycle started at enabled-edge index s is aborted at
    // edge s+TMO unless acknowledged first.
    bit            m_busy[CH];
    int            m_start[CH];
    bit            m_nxd[CH];
    bit            m_pulse;
    int            en_cnt = 0;

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
        end
    endtask

    // Monitor: one observation after every clock edge whenever an expectation is pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("busy", busy, e.busy);
                check("nxd", nxd, e.nxd);
                check("nxd_pulse", {1'b0, nxd_pulse}, {1'b0, e.pulse});
                check("wait_req", {1'b0, wait_req}, {1'b0, |e.busy});
            end
        end
    end

    task automatic step(input bit r, input bit ce, input bit [CH-1:0] s,
                        input bit [CH-1:0] a, input bit c);
        exp_t e;
        bit   any;
        @(negedge clk);
        rst = r; clken = ce; start = s; ack = a; clr_nxd = c;
        if (!r) begin
            for (int i = 0; i < CH; i++) begin
                m_busy[i] = 0;
                m_nxd[i]  = 0;
            end
            m_pulse = 0;
        end else if (ce) begin
            en_cnt++;
            any = 0;
            for (int i = 0; i < CH; i++) begin
                bit t;
                t = 0;
                if (m_busy[i]) begin
                    if (a[i]) begin
                        m_busy[i] = 0;
                    end else if (en_cnt - m_start[i] == TMO) begin
                        m_busy[i] = 0;
                        t = 1;
                        any = 1;
                    end
                end else if (s[i]) begin
                    m_busy[i]  = 1;
                    m_start[i] = en_cnt;
                end
                if (t) m_nxd[i] = 1;
                else if (c) m_nxd[i] = 0;
            end
            m_pulse = any;
        end
        for (int i = 0; i < CH; i++) begin
            e.busy[i] = m_busy[i];
            e.nxd[i]  = m_nxd[i];
        end
        e.pulse = m_pulse;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 1, 2'b00, 2'b00, 0);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            m_busy[i] = 0; m_nxd[i] = 0; m_start[i] = 0;
        end
        m_pulse = 0;

        // Reset with start asserted
        step(0, 1, 2'b11, 2'b00, 0);
        step(0, 0, 2'b11, 2'b00, 0);
        idle(2);

        // Normal IO cycle, ack five cycles later
        step(1, 1, 2'b10, 2'b00, 0);
        idle(4);
        step(1, 1, 2'b00, 2'b10, 0);
        idle(2);

        // Timeout on channel 0, then clear
        step(1, 1, 2'b01, 2'b00, 0);
        idle(10);
        step(1, 1, 2'b00, 2'b00, 1);
        idle(1);

        // Ack on the timeout edge
        step(1, 1, 2'b01, 2'b00, 0);
        idle(7);
        step(1, 1, 2'b00, 2'b01, 0);
        idle(2);

        // Clear on the timeout edge
        step(1, 1, 2'b01, 2'b00, 0);
        idle(7);
        step(1, 1, 2'b00, 2'b00, 1);
        idle(2);
        step(1, 1, 2'b00, 2'b00, 1);

        // Start and ack together in IDLE, start while busy
        step(1, 1, 2'b01, 2'b01, 0);
        idle(2);
        step(1, 1, 2'b01, 2'b00, 0);
        idle(2);
        step(1, 1, 2'b00, 2'b01, 0);
        idle(1);

        // Clock-enable stall mid-count
        step(1, 1, 2'b01, 2'b00, 0);
        idle(3);
        for (int k = 0; k < 20; k++) step(1, 0, 2'b00, 2'b01, 1);
        idle(8);
        step(1, 1, 2'b00, 2'b00, 1);

        // Reset during busy, late ack ignored
        step(1, 1, 2'b11, 2'b00, 0);
        idle(2);
        step(0, 1, 2'b00, 2'b00, 0);
        step(1, 1, 2'b00, 2'b11, 0);
        idle(2);

        // Both channels time out together
        step(1, 1, 2'b11, 2'b00, 0);
        idle(10);
        step(1, 1, 2'b00, 2'b00, 1);

        // Back-to-back timeouts on successive edges
        step(1, 1, 2'b01, 2'b00, 0);
        step(1, 1, 2'b10, 2'b00, 0);
        idle(10);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            bit            r, ce, c;
            bit [CH-1:0]   s, a;
            r  = ($urandom_range(0, 199) != 0);
            ce = ($urandom_range(0, 4) != 0);
            c  = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < CH; i++) begin
                s[i] = ($urandom_range(0, 3) == 0);
                a[i] = ($urandom_range(0, 11) == 0);
            end
            step(r, ce, s, a, c);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
